// File: rtl/intc_timer.sv
// intc_timer: 16-line interrupt controller with a 32-bit countdown timer driving line 0.
module intc_timer #(
  parameter logic [17:0] BASE_ADDR = 18'h3FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [14:0] ext_irq,
  input  logic [3:0]  wr_we,
  input  logic [17:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [17:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic [15:0] interrupts
);
  logic [15:0] pending_q, pending_d, enable_q, enable_d;
  logic [31:0] reload_q, reload_d, count_q, count_d, rd_data_q, rd_data_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [14:0] mode_q, mode_d, irq_prev_q;
  logic        rd_hit_q, rd_hit_d;
  logic        wr_hit, w_pend, w_en, w_rel, w_ctrl, w_mode;
  logic        tick, expire, rearm;
  logic [31:0] wmask, rd_val;
  logic [15:0] src_set, w1c;
  logic        unused;
  assign unused = ^{wr_addr[1:0], rd_addr[1:0]};
  assign wmask  = {{8{wr_we[3]}}, {8{wr_we[2]}}, {8{wr_we[1]}}, {8{wr_we[0]}}};
  assign wr_hit = (wr_addr[17:5] == BASE_ADDR[17:5]) && |wr_we;
  assign w_pend = wr_hit && wr_addr[4:2] == 3'd0;
  assign w_en   = wr_hit && wr_addr[4:2] == 3'd1;
  assign w_rel  = wr_hit && wr_addr[4:2] == 3'd2;
  assign w_ctrl = wr_hit && wr_addr[4:2] == 3'd4;
  assign w_mode = wr_hit && wr_addr[4:2] == 3'd5;
  assign w1c    = w_pend ? wr_data[15:0] & wmask[15:0] : 16'h0;
  // A RELOAD write preempts the countdown, so it suppresses both decrement and event
  assign tick   = ctrl_q[0] && count_q != '0 && !w_rel;
  assign expire = tick && count_q == 32'd1;
  assign rearm  = ctrl_q[1] && reload_q != '0;
  // Edge lines need a 0->1 transition against the sampled history; level lines set on any high
  assign src_set = {ext_irq & (~mode_q | ~irq_prev_q), expire};
  always_comb begin
    enable_d  = w_en ? (enable_q & ~wmask[15:0]) | (wr_data[15:0] & wmask[15:0]) : enable_q;
    reload_d  = w_rel ? (reload_q & ~wmask) | (wr_data & wmask) : reload_q;
    mode_d    = w_mode ? (mode_q & ~wmask[15:1]) | (wr_data[15:1] & wmask[15:1]) : mode_q;
    ctrl_d    = w_ctrl ? (ctrl_q & ~wmask[1:0]) | (wr_data[1:0] & wmask[1:0]) : ctrl_q;
    pending_d = (pending_q & ~w1c) | src_set;
    count_d   = w_rel ? reload_d : !tick ? count_q : !expire ? count_q - 32'd1 : rearm ? reload_q : '0;
    if (expire && !rearm) ctrl_d[0] = 1'b0;
    case (rd_addr[4:2])
      3'd0:    rd_val = {16'h0, pending_q};
      3'd1:    rd_val = {16'h0, enable_q};
      3'd2:    rd_val = reload_q;
      3'd3:    rd_val = count_q;
      3'd4:    rd_val = {30'h0, ctrl_q};
      3'd5:    rd_val = {16'h0, mode_q, 1'b0};
      default: rd_val = '0;
    endcase
    rd_hit_d  = rd_addr[17:5] == BASE_ADDR[17:5];
    rd_data_d = rd_hit_d ? rd_val : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      enable_q   <= '0;
      reload_q   <= '0;
      count_q    <= '0;
      ctrl_q     <= '0;
      mode_q     <= 15'h7FFF;
      irq_prev_q <= '0;
      rd_data_q  <= '0;
      rd_hit_q   <= 1'b0;
    end else if (clk_en) begin
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_d;
      mode_q     <= mode_d;
      irq_prev_q <= ext_irq;
      rd_data_q  <= rd_data_d;
      rd_hit_q   <= rd_hit_d;
    end
  end
  assign rd_data    = rd_data_q;
  assign rd_hit     = rd_hit_q;
  assign interrupts = pending_q & enable_q;
endmodule

// File: tb/tb_intc_timer.sv
// tb_intc_timer: directed register/timer vectors with a queued scoreboard checked by a read monitor.
module tb_intc_timer;
  localparam logic [17:0] BASE = 18'h3FF00;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [14:0] ext_irq = '0;
  logic [3:0]  wr_we = '0;
  logic [17:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [17:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [15:0] interrupts;
  logic        rd_issue = 1'b0;
  logic [31:0] q_d[$];
  logic        q_h[$];
  logic [15:0] q_i[$];
  string       q_n[$];
  int n_chk = 0;
  int n_fail = 0;
  intc_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .ext_irq(ext_irq),
    .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit), .interrupts(interrupts)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    wr_we = '0;
    rd_issue = 1'b0;
  endtask
  task automatic pulse();
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clk_en = 1'b1;
    cyc();
  endtask
  task automatic wr(input logic [17:0] off, input logic [3:0] we, input logic [31:0] d);
    wr_addr = BASE + off;
    wr_we = we;
    wr_data = d;
  endtask
  task automatic rd(input logic [17:0] off, input logic [31:0] d, input logic h, input logic [15:0] irq, input string nm);
    rd_addr = BASE + off;
    rd_issue = 1'b1;
    q_d.push_back(d);
    q_h.push_back(h);
    q_i.push_back(irq);
    q_n.push_back(nm);
  endtask
  initial begin : monitor
    bit t;
    string nm;
    forever begin
      @(posedge clk);
      t = rd_issue && clk_en && rst_n;
      @(negedge clk);
      if (t) begin
        if (q_d.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_read: got %h, want no read", rd_data);
        end else begin
          nm = q_n.pop_front();
          check({nm, "_data"}, rd_data, q_d.pop_front());
          check({nm, "_hit"}, {31'h0, rd_hit}, {31'h0, q_h.pop_front()});
          check({nm, "_irq"}, {16'h0, interrupts}, {16'h0, q_i.pop_front()});
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    clk_en = 1'b1;
    rd(0, 0, 1, 0, "rst_pend"); cyc();
    rd(18'h14, 32'hFFFE, 1, 0, "rst_mode"); cyc();
    rd(18'h0C, 0, 1, 0, "rst_count"); cyc();
    rd(18'h18, 0, 1, 0, "rsvd"); cyc();
    rd(18'h40, 0, 0, 0, "miss"); cyc();
    // edge-triggered line 2
    wr(18'h04, 4'hF, 32'h4); cyc();
    ext_irq = 15'h0002; rd(0, 0, 1, 16'h4, "edge_set"); cyc();
    rd(0, 32'h4, 1, 16'h4, "edge_hold"); cyc();
    wr(0, 4'h1, 32'h4); rd(0, 32'h4, 1, 0, "edge_w1c"); cyc();
    rd(0, 0, 1, 0, "edge_noreset"); cyc();
    ext_irq = '0;
    // level-triggered line 3
    wr(18'h14, 4'h3, 32'hFFF6); cyc();
    wr(18'h04, 4'hF, 32'h8); rd(18'h14, 32'hFFF6, 1, 0, "mode_rb"); cyc();
    ext_irq = 15'h0004; rd(0, 0, 1, 16'h8, "lvl_set"); cyc();
    wr(0, 4'h1, 32'h8); rd(0, 32'h8, 1, 16'h8, "lvl_setwins"); cyc();
    ext_irq = '0; rd(0, 32'h8, 1, 16'h8, "lvl_hold"); cyc();
    wr(0, 4'h1, 32'h8); rd(0, 32'h8, 1, 0, "lvl_clr"); cyc();
    rd(0, 0, 1, 0, "lvl_gone"); cyc();
    // periodic timer
    wr(18'h04, 4'hF, 32'h1); cyc();
    wr(18'h08, 4'hF, 32'd3); cyc();
    wr(18'h10, 4'hF, 32'd3); rd(18'h0C, 3, 1, 0, "per_c0"); cyc();
    rd(18'h0C, 3, 1, 0, "per_c1"); cyc();
    rd(18'h0C, 2, 1, 0, "per_c2"); cyc();
    rd(18'h0C, 1, 1, 16'h1, "per_c3"); cyc();
    wr(0, 4'hF, 32'h1); rd(18'h0C, 3, 1, 0, "per_c4"); cyc();
    rd(18'h0C, 2, 1, 0, "per_c5"); cyc();
    rd(18'h0C, 1, 1, 16'h1, "per_c6"); cyc();
    wr(0, 4'hF, 32'h1); rd(18'h0C, 3, 1, 0, "per_c7"); cyc();
    wr(18'h10, 4'hF, 0); rd(18'h10, 3, 1, 0, "per_ctrl"); cyc();
    // one-shot timer and reload-wins
    wr(18'h08, 4'hF, 32'd2); rd(18'h0C, 1, 1, 0, "os_c0"); cyc();
    wr(18'h10, 4'hF, 32'd1); cyc();
    rd(18'h0C, 2, 1, 0, "os_c1"); cyc();
    rd(18'h0C, 1, 1, 16'h1, "os_c2"); cyc();
    rd(18'h10, 0, 1, 16'h1, "os_ctrl"); cyc();
    wr(0, 4'hF, 32'h1); rd(18'h0C, 0, 1, 0, "os_idle"); cyc();
    wr(18'h08, 4'hF, 32'd5); cyc();
    wr(18'h10, 4'hF, 32'd1); cyc();
    repeat (4) cyc();
    wr(18'h08, 4'hF, 32'd7); rd(18'h0C, 1, 1, 0, "rl_wins"); cyc();
    rd(0, 0, 1, 0, "rl_noevt"); cyc();
    wr(18'h10, 4'hF, 0); cyc();
    // clk_en pulsing 1-in-4
    wr(18'h08, 4'hF, 32'd10); cyc();
    wr(18'h10, 4'hF, 32'd1); cyc();
    rd(18'h0C, 32'd10, 1, 0, "ce_c0"); pulse();
    rd(18'h0C, 32'd9, 1, 0, "ce_c1"); pulse();
    rd(18'h40, 0, 0, 0, "ce_miss"); pulse();
    rd(18'h0C, 32'd7, 1, 0, "ce_c2"); pulse();
    ext_irq = 15'h0002; rd(0, 0, 1, 0, "ce_samp"); pulse();
    rd(0, 32'h4, 1, 0, "ce_pend"); pulse();
    ext_irq = '0; wr(18'h10, 4'hF, 0); cyc();
    // byte lanes, reserved space and address aliasing
    wr(18'h04, 4'hF, 32'h55); cyc();
    wr(18'h04, 4'b0010, 32'h0000AB00); cyc();
    rd(18'h04, 32'hAB55, 1, 16'h4, "byte_keep"); cyc();
    wr(18'h04, 4'hF, 32'hFFFF0000); cyc();
    wr(18'h04, 4'b0010, 32'h0000AB00); cyc();
    rd(18'h04, 32'hAB00, 1, 0, "byte_wr"); cyc();
    wr(18'h18, 4'hF, 32'hFFFFFFFF); rd(18'h06, 32'hAB00, 1, 0, "addr_lsb"); cyc();
    rd(18'h18, 0, 1, 0, "rsvd_wr"); cyc();
    wr(18'h44, 4'hF, 32'hFFFF); cyc();
    rd(18'h04, 32'hAB00, 1, 0, "miss_wr"); cyc();
    // reset mid-countdown
    wr(18'h04, 4'hF, 32'hFFFF); cyc();
    wr(18'h08, 4'hF, 32'd5); rd(0, 32'h4, 1, 16'h4, "pre_rst"); cyc();
    wr(18'h10, 4'hF, 32'd1); cyc();
    cyc();
    rst_n = 1'b0; clk_en = 1'b0; cyc();
    rst_n = 1'b1; clk_en = 1'b1;
    rd(0, 0, 1, 0, "post_rst_pend"); cyc();
    rd(18'h0C, 0, 1, 0, "post_rst_count"); cyc();
    rd(18'h10, 0, 1, 0, "post_rst_ctrl"); cyc();
    rd(18'h04, 0, 1, 0, "post_rst_en"); cyc();
    repeat (3) cyc();
    if (q_d.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q_d.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
